reg_bus_master: RTL
===================

# reg_bus_master

Initiator for the four-register device register interface: the address, write_en, read_en, data_in and read_data bus. It accepts register commands over a valid/ready port and drives the single-cycle write and read strobes. Read data is captured after the responder's registered one-cycle read latency, and each result is returned on a valid/ready response port. Supported operations are write, read, read-modify-write and poll-until-match with a timeout. The block sits between a sequencer or bench driver and any responder on this bus.

## Interface
- ADDR_W, 4, device address width
- DATA_W, 8, device data width
- POLL_MAX, 16, maximum read attempts per poll command (1..255)
- clk  in  1  clock; all logic is rising-edge
- resetb  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  operation: 0 WRITE, 1 READ, 2 RMW, 3 POLL
- cmd_addr  in  ADDR_W  register address
- cmd_data  in  DATA_W  data to write (WRITE), new bits (RMW), or expected value (POLL)
- cmd_mask  in  DATA_W  bits to replace (RMW) or bits to compare (POLL); ignored for WRITE and READ
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  DATA_W  WRITE: data written; READ: data read; RMW: new value; POLL: last value read
- rsp_err  out  1  poll timed out; 0 for all other operations
- address  out  ADDR_W  device address
- write_en  out  1  device write strobe
- read_en  out  1  device read strobe
- data_in  out  DATA_W  device write data
- read_data  in  DATA_W  device read data, registered in the responder

## Operation
- States: IDLE, WR, RD, RWAIT, MODW, RESP.
- cmd_ready = (state == IDLE). All device-side outputs and all rsp_* outputs are registered.
- Command capture: on acceptance, cmd_op, cmd_addr, cmd_data and cmd_mask are latched. Later changes on the cmd_* inputs have no effect.
- WRITE sequence: IDLE → WR → RESP.
  - WR drives write_en=1, address and data_in for exactly one cycle.
- READ sequence: IDLE → RD → RWAIT → RESP.
  - RD drives read_en=1 for one cycle.
  - In RWAIT, read_data is valid and is captured into rsp_data at the end of that cycle.
- RMW sequence: RD → RWAIT → MODW → RESP.
  - MODW writes new = (old & ~mask) | (data & mask).
  - rsp_data = new.
- POLL sequence: RD → RWAIT, repeated.
  - In RWAIT, match = ((rd ^ data) & mask) == 0.
  - On match: go to RESP with rsp_err=0.
  - Otherwise, if the attempt count equals POLL_MAX: go to RESP with rsp_err=1.
  - Otherwise: increment the attempt count and go to RD.
  - The attempt counter has width 8 and clears on acceptance.
  - mask=0 matches on the first attempt.
- RESP: rsp_valid is held with stable data until rsp_ready. The state returns to IDLE on the handshake.
- Strobes: write_en and read_en are never high together, and never high outside WR/MODW and RD respectively.
- Bus hold: between accesses, address and data_in hold their last driven value.
- Unmapped addresses (above 3 in the four-register responder): writes are dropped by the responder. Reads return the responder's previously held read_data, which is passed through unchanged with rsp_err=0.

## Timing
- Reset values:
  - state IDLE, so cmd_ready=1.
  - rsp_valid, rsp_data, rsp_err: 0.
  - address, write_en, read_en, data_in: 0.
  - Attempt counter: 0.
- Reset mid-operation: outputs go to their reset values asynchronously, the in-flight command is discarded, and no strobe is emitted after release.
- Latency, counted from the accept edge to the first cycle with rsp_valid=1:
  - WRITE: 2 cycles.
  - READ: 3 cycles.
  - RMW: 4 cycles.
  - POLL: 1 + 2·n cycles for n attempts.
- Throughput with rsp_ready held high: the next command is accepted one cycle after the response handshake. A back-to-back write therefore takes 3 cycles.
- Response back-pressure: a held rsp_valid stalls command acceptance indefinitely. No command is ever accepted while rsp_valid=1.

## Structure
- Package reg_bus_pkg holds:
  - op encodings OP_WRITE, OP_READ, OP_RMW, OP_POLL;
  - the state enum;
  - merge and match functions (mask merge, masked compare).
- Single module; no sub-module is warranted. The poll counter and sequencing stay in the FSM.

## Test plan
- Write then read: WRITE addr 2 data 0xA5, then READ addr 2. Required: write_en high for exactly one cycle with address=2, data_in=0xA5; the read returns rsp_data=0xA5 three cycles after acceptance.
- RMW: preload reg1=0xF0, then RMW addr 1 data 0x0F mask 0x3C. Required: the device is written with 0xCC; rsp_data=0xCC; a following READ returns 0xCC.
- Poll success: POLL addr 3 expect 0x80 mask 0x80. The bench writes reg3=0x81 through a second master port model after the third attempt. Required: rsp_err=0, rsp_data=0x81, and read_en pulse count of 4.
- Poll timeout: POLL addr 0 expect 0x01 mask 0x01 with reg0=0 and POLL_MAX=16. Required: exactly 16 read_en pulses, then rsp_err=1, rsp_data=0x00.
- Back-pressure: hold rsp_ready=0 for 10 cycles after a READ and keep cmd_valid=1. Required: rsp_valid and rsp_data are stable and cmd_ready=0 throughout; the next command is accepted one cycle after rsp_ready rises.
- Reset mid-RMW: assert resetb=0 during RWAIT. Required: all outputs are 0 immediately, cmd_ready=1 after release, no MODW write occurs, and the register value is unchanged.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared types and helpers for the register-bus initiator.
// Op encodings, FSM states, and the mask merge / masked compare used by RMW and POLL.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_RMW   = 2'd2,
        OP_POLL  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_MODW  = 3'd4,
        S_RESP  = 3'd5
    } state_e;

    localparam int CNT_W = 8;
    localparam int MAX_W = 64;

    // Callers zero-extend to MAX_W and truncate the result back.
    function automatic logic [MAX_W-1:0] merge(
        input logic [MAX_W-1:0] old_val,
        input logic [MAX_W-1:0] new_bits,
        input logic [MAX_W-1:0] mask
    );
        return (old_val & ~mask) | (new_bits & mask);
    endfunction

    function automatic logic match(
        input logic [MAX_W-1:0] rd,
        input logic [MAX_W-1:0] expect_val,
        input logic [MAX_W-1:0] mask
    );
        return ((rd ^ expect_val) & mask) == '0;
    endfunction

endpackage

// File: rtl/reg_bus_if.sv
// reg_bus_if: command/response handshake plus the device register bus.
// master is the initiator's view; slave is the driver-and-responder side.
interface reg_bus_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output address, write_en, read_en, data_in,
        input  read_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  address, write_en, read_en, data_in,
        output read_data
    );

endinterface

// File: rtl/reg_bus_master.sv
// reg_bus_master: command-driven initiator for the four-register device bus.
// Sequences write, read, read-modify-write and bounded poll accesses.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int POLL_MAX = 16
) (
    input logic       clk,
    input logic       resetb,
    reg_bus_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_MAX - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              write_en_q, write_en_d;
    logic              read_en_q, read_en_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;

    logic              accept;
    logic              hit;
    logic              poll_done;
    logic [DATA_W-1:0] new_val;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    assign hit = match(MAX_W'(bus.read_data),
                       MAX_W'(data_q),
                       MAX_W'(mask_q));

    // cnt_q counts completed retries, so the last attempt sees POLL_MAX-1.
    assign poll_done = hit || (cnt_q == CNT_LAST);

    assign new_val = DATA_W'(merge(MAX_W'(bus.read_data),
                                   MAX_W'(data_q),
                                   MAX_W'(mask_q)));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            address_q   <= '0;
            write_en_q  <= 1'b0;
            read_en_q   <= 1'b0;
            data_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            address_q   <= address_d;
            write_en_q  <= write_en_d;
            read_en_q   <= read_en_d;
            data_in_q   <= data_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (op_e'(bus.cmd_op) == OP_WRITE) state_d = S_WR;
                    else                               state_d = S_RD;
                end
            end
            S_WR:   state_d = S_RESP;
            S_RD:   state_d = S_RWAIT;
            S_RWAIT: begin
                unique case (op_q)
                    OP_WRITE: state_d = S_RESP;
                    OP_READ:  state_d = S_RESP;
                    OP_RMW:   state_d = S_MODW;
                    OP_POLL:  state_d = poll_done ? S_RESP : S_RD;
                endcase
            end
            S_MODW: state_d = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are loaded from the state being entered.
    always_comb begin
        op_d        = op_q;
        data_d      = data_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        address_d   = address_q;
        data_in_d   = data_in_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        write_en_d  = (state_d == S_WR) || (state_d == S_MODW);
        read_en_d   = (state_d == S_RD);
        rsp_valid_d = (state_d == S_RESP);
        unique case (1'b1)
            accept: begin
                op_d      = op_e'(bus.cmd_op);
                data_d    = bus.cmd_data;
                mask_d    = bus.cmd_mask;
                cnt_d     = '0;
                address_d = bus.cmd_addr;
                if (op_e'(bus.cmd_op) == OP_WRITE) data_in_d = bus.cmd_data;
            end
            (state_q == S_WR): begin
                rsp_data_d = data_q;
                rsp_err_d  = 1'b0;
            end
            (state_q == S_RWAIT): begin
                rsp_data_d = bus.read_data;
                rsp_err_d  = 1'b0;
                if (op_q == OP_RMW) data_in_d = new_val;
                if (op_q == OP_POLL) begin
                    rsp_err_d = poll_done && !hit;
                    if (!poll_done) cnt_d = cnt_q + 1'b1;
                end
            end
            (state_q == S_MODW): begin
                rsp_data_d = data_in_q;
                rsp_err_d  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.address   = address_q;
    assign bus.write_en  = write_en_q;
    assign bus.read_en   = read_en_q;
    assign bus.data_in   = data_in_q;

endmodule
